// File: rtl/reg_scoreboard_if.sv
// Issue/retire handshake bundle between the ID/WB pipeline control and the
// register scoreboard. The pipeline side is the master; the scoreboard is the slave.
interface reg_scoreboard_if;
  logic        issue_valid;
  logic [3:0]  issue_dest;
  logic        issue_wb_en;
  logic        issue_is_load;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic        freeze;
  logic        flush;
  logic        retire_valid;
  logic        retire_wb_en;
  logic [3:0]  retire_dest;
  logic        hazard;
  logic        issue_accept;
  logic [15:0] busy;
  logic        ovf_err;
  logic        unf_err;

  modport master (
    output issue_valid, issue_dest, issue_wb_en, issue_is_load,
    output src1, src2, two_src, freeze, flush,
    output retire_valid, retire_wb_en, retire_dest,
    input  hazard, issue_accept, busy, ovf_err, unf_err
  );

  modport slave (
    input  issue_valid, issue_dest, issue_wb_en, issue_is_load,
    input  src1, src2, two_src, freeze, flush,
    input  retire_valid, retire_wb_en, retire_dest,
    output hazard, issue_accept, busy, ovf_err, unf_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard with EXE load tracking; raises the ID
// stall either on load-use only (forwarding present) or on any pending write.
module reg_scoreboard #(
  parameter int unsigned FWD_EN = 1
) (
  input logic              clk,
  input logic              rst,
  reg_scoreboard_if.slave  sb
);

  logic [1:0]  pend     [16];
  logic [1:0]  pend_nxt [16];
  logic        ld_v;
  logic [3:0]  ld_dest;
  logic        ovf_q;
  logic        unf_q;

  logic        inc_en;
  logic        dec_en;
  logic [15:0] inc_vec;
  logic [15:0] dec_vec;
  logic [15:0] busy_c;
  logic        ovf_set;
  logic        unf_set;
  logic        hazard_c;
  logic        accept_c;

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      busy_c[r] = (pend[r] != 2'd0);
    end
  end

  // Stall decision is purely combinational so a dependent op holds in ID
  // during the very cycle the conflict exists.
  if (FWD_EN != 0) begin : g_fwd
    always_comb begin
      hazard_c = sb.issue_valid & ld_v &
                 ((sb.src1 == ld_dest) | (sb.two_src & (sb.src2 == ld_dest)));
    end
  end else begin : g_nofwd
    always_comb begin
      hazard_c = sb.issue_valid &
                 (busy_c[sb.src1] | (sb.two_src & busy_c[sb.src2]));
    end
  end

  always_comb begin
    accept_c = sb.issue_valid & ~hazard_c & ~sb.freeze & ~sb.flush;
    inc_en   = accept_c & sb.issue_wb_en;
    dec_en   = sb.retire_valid & sb.retire_wb_en & ~sb.freeze;
    inc_vec  = inc_en ? (16'h0001 << sb.issue_dest)  : 16'h0000;
    dec_vec  = dec_en ? (16'h0001 << sb.retire_dest) : 16'h0000;
  end

  // NOTE: every variable in this block gets a default before any branch,
  // otherwise the untaken paths would infer latches.
  always_comb begin
    ovf_set = 1'b0;
    unf_set = 1'b0;
    for (int r = 0; r < 16; r++) begin
      pend_nxt[r] = pend[r];
      case ({inc_vec[r], dec_vec[r]})
        2'b10: begin
          if (pend[r] == 2'd3) ovf_set = 1'b1;
          else                 pend_nxt[r] = pend[r] + 2'd1;
        end
        2'b01: begin
          if (pend[r] == 2'd0) unf_set = 1'b1;
          else                 pend_nxt[r] = pend[r] - 2'd1;
        end
        default: pend_nxt[r] = pend[r];
      endcase
    end
  end

  // NOTE: the count array is only 16x2 flops and must read as empty after
  // reset, so it is cleared explicitly rather than treated as a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) begin
        pend[r] <= 2'd0;
      end
    end else begin
      for (int r = 0; r < 16; r++) begin
        pend[r] <= pend_nxt[r];
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  // The EXE tracker freezes with the pipeline; a stalled or flushed ID slot
  // sends a bubble into EXE, which clears ld_v.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_v    <= 1'b0;
      ld_dest <= 4'd0;
    end else if (!sb.freeze) begin
      ld_v    <= accept_c & sb.issue_wb_en & sb.issue_is_load;
      ld_dest <= sb.issue_dest;
    end
  end

  assign sb.hazard       = hazard_c;
  assign sb.issue_accept = accept_c;
  assign sb.busy         = busy_c;
  assign sb.ovf_err      = ovf_q;
  assign sb.unf_err      = unf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: one forwarding and one non-forwarding
// instance, exercised by hand-computed vectors.
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reg_scoreboard_if f_if ();
  reg_scoreboard_if n_if ();

  reg_scoreboard #(.FWD_EN(1)) f_dut (.clk(clk), .rst(rst), .sb(f_if.slave));
  reg_scoreboard #(.FWD_EN(0)) n_dut (.clk(clk), .rst(rst), .sb(n_if.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic f_issue(input logic v, input logic [3:0] d, input logic wb, input logic ld,
                         input logic [3:0] s1, input logic [3:0] s2, input logic two);
    f_if.issue_valid = v;  f_if.issue_dest = d; f_if.issue_wb_en = wb;
    f_if.issue_is_load = ld; f_if.src1 = s1; f_if.src2 = s2; f_if.two_src = two;
    #1;
  endtask

  task automatic n_issue(input logic v, input logic [3:0] d, input logic wb, input logic ld,
                         input logic [3:0] s1, input logic [3:0] s2, input logic two);
    n_if.issue_valid = v;  n_if.issue_dest = d; n_if.issue_wb_en = wb;
    n_if.issue_is_load = ld; n_if.src1 = s1; n_if.src2 = s2; n_if.two_src = two;
    #1;
  endtask

  task automatic f_retire(input logic v, input logic [3:0] d);
    f_if.retire_valid = v; f_if.retire_wb_en = v; f_if.retire_dest = d;
    #1;
  endtask

  task automatic n_retire(input logic v, input logic [3:0] d);
    n_if.retire_valid = v; n_if.retire_wb_en = v; n_if.retire_dest = d;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    f_if.freeze = 1'b0; f_if.flush = 1'b0;
    n_if.freeze = 1'b0; n_if.flush = 1'b0;
    f_issue(1'b1, 4'd1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);  // rst must override this issue
    n_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    f_retire(1'b0, 4'd0);
    n_retire(1'b0, 4'd0);
    tick();
    tick();
    f_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_busy_f", 32'(f_if.busy), 32'h0000);
    check("rst_busy_n", 32'(n_if.busy), 32'h0000);
    check("rst_hazard", 32'(f_if.hazard), 32'd0);
    check("rst_ovf", 32'(f_if.ovf_err), 32'd0);
    check("rst_unf", 32'(f_if.unf_err), 32'd0);
    check("rst_ld_v", 32'(f_dut.ld_v), 32'd0);

    // Load-use: LDR R3 then ADD src1=3 stalls exactly one cycle
    f_issue(1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    check("ldr_accept", 32'(f_if.issue_accept), 32'd1);
    tick();
    f_issue(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
    check("lu_hazard", 32'(f_if.hazard), 32'd1);
    check("lu_accept", 32'(f_if.issue_accept), 32'd0);
    check("lu_busy", 32'(f_if.busy), 32'h0008);
    tick();
    check("lu_hazard_clr", 32'(f_if.hazard), 32'd0);
    check("lu_accept_now", 32'(f_if.issue_accept), 32'd1);
    tick();
    f_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check("lu_busy2", 32'(f_if.busy), 32'h0018);
    f_retire(1'b1, 4'd3);
    tick();
    f_retire(1'b1, 4'd4);
    tick();
    f_retire(1'b0, 4'd0);
    check("lu_drained", 32'(f_if.busy), 32'h0000);

    // ALU producer: no stall with forwarding, busy until retire
    f_issue(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    f_issue(1'b1, 4'd6, 1'b0, 1'b0, 4'd3, 4'd0, 1'b0);
    check("alu_hazard", 32'(f_if.hazard), 32'd0);
    check("alu_accept", 32'(f_if.issue_accept), 32'd1);
    tick();
    f_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check("alu_busy", 32'(f_if.busy), 32'h0008);
    f_retire(1'b1, 4'd3);
    tick();
    f_retire(1'b0, 4'd0);
    check("alu_drained", 32'(f_if.busy), 32'h0000);

    // Same-edge issue and retire of R7 with pend[7]=1
    f_issue(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    f_retire(1'b1, 4'd7);
    tick();
    f_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    f_retire(1'b0, 4'd0);
    check("same_pend7", 32'(f_dut.pend[7]), 32'd1);
    check("same_busy", 32'(f_if.busy), 32'h0080);
    check("same_ovf", 32'(f_if.ovf_err), 32'd0);
    check("same_unf", 32'(f_if.unf_err), 32'd0);
    f_retire(1'b1, 4'd7);
    tick();
    f_retire(1'b0, 4'd0);
    check("same_drained", 32'(f_if.busy), 32'h0000);

    // Flush blocks acceptance and leaves counts alone
    f_if.flush = 1'b1;
    f_issue(1'b1, 4'd8, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    check("flush_accept", 32'(f_if.issue_accept), 32'd0);
    tick();
    f_if.flush = 1'b0;
    f_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check("flush_busy", 32'(f_if.busy), 32'h0000);

    // Overflow on fourth issue to R2, underflow on retire of idle R9
    f_issue(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    tick();
    tick();
    check("ovf_after3", 32'(f_if.ovf_err), 32'd0);
    check("pend2_is3", 32'(f_dut.pend[2]), 32'd3);
    tick();
    f_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check("ovf_after4", 32'(f_if.ovf_err), 32'd1);
    check("pend2_sat", 32'(f_dut.pend[2]), 32'd3);
    f_retire(1'b1, 4'd9);
    tick();
    f_retire(1'b0, 4'd0);
    check("unf_set", 32'(f_if.unf_err), 32'd1);
    check("unf_busy", 32'(f_if.busy), 32'h0004);
    tick();
    tick();
    check("ovf_sticky", 32'(f_if.ovf_err), 32'd1);
    check("unf_sticky", 32'(f_if.unf_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("err_clr_ovf", 32'(f_if.ovf_err), 32'd0);
    check("err_clr_unf", 32'(f_if.unf_err), 32'd0);
    check("err_clr_busy", 32'(f_if.busy), 32'h0000);

    // LDR R4 in EXE, dependent op held through 5 freeze cycles, then rst
    f_issue(1'b1, 4'd4, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    tick();
    f_if.freeze = 1'b1;
    f_issue(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("frz_hazard", 32'(f_if.hazard), 32'd1);
      check("frz_ld_v", 32'(f_dut.ld_v), 32'd1);
      tick();
    end
    check("frz_accept", 32'(f_if.issue_accept), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("frz_rst_busy", 32'(f_if.busy), 32'h0000);
    check("frz_rst_hazard", 32'(f_if.hazard), 32'd0);

    // Freeze also blocks retirement, so no underflow on an idle register
    f_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    f_retire(1'b1, 4'd1);
    tick();
    f_retire(1'b0, 4'd0);
    f_if.freeze = 1'b0;
    #1;
    check("frz_no_unf", 32'(f_if.unf_err), 32'd0);

    // No forwarding: stall on any pending write, src2 only when two_src
    n_issue(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    n_issue(1'b1, 4'd6, 1'b1, 1'b0, 4'd0, 4'd5, 1'b1);
    check("nf_haz_c1", 32'(n_if.hazard), 32'd1);
    tick();
    check("nf_haz_c2", 32'(n_if.hazard), 32'd1);
    tick();
    n_retire(1'b1, 4'd5);
    check("nf_haz_c3", 32'(n_if.hazard), 32'd1);
    check("nf_acc_c3", 32'(n_if.issue_accept), 32'd0);
    tick();
    n_retire(1'b0, 4'd0);
    check("nf_haz_clr", 32'(n_if.hazard), 32'd0);
    check("nf_acc_now", 32'(n_if.issue_accept), 32'd1);
    tick();
    n_issue(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    check("nf_busy6", 32'(n_if.busy), 32'h0040);
    tick();
    n_issue(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 4'd5, 1'b0);
    check("nf_busy56", 32'(n_if.busy), 32'h0060);
    check("nf_one_src", 32'(n_if.hazard), 32'd0);
    n_issue(1'b1, 4'd7, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0);
    check("nf_src1", 32'(n_if.hazard), 32'd1);
    n_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
